// File: rtl/dtlb_lookup_stage.sv
// rtl/dtlb_lookup_stage.sv - data-TLB lookup pipeline stage with page-walk request, fault reporting and store-data bypass
module dtlb_lookup_stage #(
    parameter int VADDR_WIDTH    = 16,
    parameter int PADDR_WIDTH    = 20,
    parameter int PAGE_BITS      = 12,
    parameter int NUM_ENTRIES    = 4,
    parameter int DATA_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 3
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 enable_tlblookup,
    input  logic                                 tlb_flush,
    input  logic [VADDR_WIDTH-1:0]               alu_result,
    input  logic [DATA_WIDTH-1:0]                dataReg,
    input  logic [REG_ADDR_WIDTH-1:0]            dataReg_addr,
    input  logic [1:0]                           ldSt_enable,
    input  logic [REG_ADDR_WIDTH-1:0]            destReg_addr_input,
    input  logic                                 we_input,
    input  logic [1:0]                           bp_input,
    output logic [PADDR_WIDTH-1:0]               tlblookup_result,
    output logic [REG_ADDR_WIDTH-1:0]            destReg_addr_output,
    output logic                                 we_output,
    output logic [1:0]                           bp_output,
    output logic [1:0]                           ldSt_enable_output,
    output logic [DATA_WIDTH-1:0]                dataReg_output,
    output logic                                 blockPreviousStages,
    output logic                                 walk_req,
    output logic [VADDR_WIDTH-PAGE_BITS-1:0]     walk_vpn,
    input  logic                                 walk_valid,
    input  logic                                 walk_fault,
    input  logic                                 walk_writable,
    input  logic [PADDR_WIDTH-PAGE_BITS-1:0]     walk_ppn,
    output logic                                 exc_valid,
    output logic [VADDR_WIDTH-1:0]               exc_vaddr,
    input  logic [REG_ADDR_WIDTH-1:0]            destReg_addrCACHE,
    input  logic                                 weCACHE,
    input  logic [DATA_WIDTH-1:0]                cache_result,
    input  logic [REG_ADDR_WIDTH-1:0]            destReg_addrWB,
    input  logic                                 weWB,
    input  logic [DATA_WIDTH-1:0]                wb_result
);

    localparam int VPN_W = VADDR_WIDTH - PAGE_BITS;
    localparam int PPN_W = PADDR_WIDTH - PAGE_BITS;
    localparam int IDX_W = $clog2(NUM_ENTRIES);

    typedef enum logic [1:0] {ST_IDLE, ST_WALK, ST_FAULT} state_t;

    state_t                    state;

    logic [VADDR_WIDTH-1:0]    va_reg;
    logic [DATA_WIDTH-1:0]     data_reg;
    logic [REG_ADDR_WIDTH-1:0] data_addr_reg;
    logic [1:0]                ldst_reg;
    logic [REG_ADDR_WIDTH-1:0] dest_reg;
    logic                      we_reg;
    logic [1:0]                bp_reg;

    logic [NUM_ENTRIES-1:0]    ent_valid;
    logic [NUM_ENTRIES-1:0]    ent_writable;
    logic [VPN_W-1:0]          ent_vpn [NUM_ENTRIES];
    logic [PPN_W-1:0]          ent_ppn [NUM_ENTRIES];
    logic [IDX_W-1:0]          rr_ptr;

    logic [VPN_W-1:0]          cur_vpn;
    logic                      match;
    logic                      match_wr;
    logic [PPN_W-1:0]          match_ppn;
    logic                      mem_op;
    logic                      is_store;
    logic                      prot_fault;
    logic                      block;
    logic                      nop_out;
    logic [IDX_W-1:0]          victim;
    logic                      victim_is_ptr;
    logic                      fill_en;

    assign cur_vpn    = va_reg[VADDR_WIDTH-1:PAGE_BITS];
    assign mem_op     = (ldst_reg != 2'b00);
    assign is_store   = ldst_reg[1];
    assign prot_fault = match && is_store && !match_wr;
    assign block      = (state == ST_WALK) ||
                        ((state == ST_IDLE) && mem_op && (!match || prot_fault));
    assign nop_out    = block || (state == ST_FAULT);
    // A flush in the fill cycle wins: the entry is not written and the instruction walks again.
    assign fill_en    = (state == ST_WALK) && walk_valid && !walk_fault && !tlb_flush;

    // Fully associative match on the registered VPN; fills only happen on a miss, so at most one hit.
    always_comb begin
        match     = 1'b0;
        match_wr  = 1'b0;
        match_ppn = '0;
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            if (ent_valid[i] && (ent_vpn[i] == cur_vpn)) begin
                match     = 1'b1;
                match_wr  = match_wr | ent_writable[i];
                match_ppn = match_ppn | ent_ppn[i];
            end
        end
    end

    // Victim: lowest-index invalid entry, otherwise the round-robin pointer.
    always_comb begin
        victim        = rr_ptr;
        victim_is_ptr = 1'b1;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            if (!ent_valid[i]) begin
                victim        = IDX_W'(i);
                victim_is_ptr = 1'b0;
            end
        end
    end

    // TLB array: fill on a successful walk response, flush clears every valid bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            ent_valid    <= '0;
            ent_writable <= '0;
            rr_ptr       <= '0;
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                ent_vpn[i] <= '0;
                ent_ppn[i] <= '0;
            end
        end else begin
            if (fill_en) begin
                ent_valid[victim]    <= 1'b1;
                ent_writable[victim] <= walk_writable;
                ent_vpn[victim]      <= cur_vpn;
                ent_ppn[victim]      <= walk_ppn;
                if (victim_is_ptr) begin
                    rr_ptr <= (rr_ptr == IDX_W'(NUM_ENTRIES - 1)) ? '0 : rr_ptr + IDX_W'(1);
                end
            end
            if (tlb_flush) begin
                ent_valid <= '0;
            end
        end
    end

    // Stage register: holds while stalled; a fault slot with no new instruction becomes a nop.
    always_ff @(posedge clk) begin
        if (reset) begin
            va_reg        <= '0;
            data_reg      <= '0;
            data_addr_reg <= '0;
            ldst_reg      <= '0;
            dest_reg      <= '0;
            we_reg        <= 1'b0;
            bp_reg        <= '0;
        end else if (enable_tlblookup && !block) begin
            va_reg        <= alu_result;
            data_reg      <= dataReg;
            data_addr_reg <= dataReg_addr;
            ldst_reg      <= ldSt_enable;
            dest_reg      <= destReg_addr_input;
            we_reg        <= we_input;
            bp_reg        <= bp_input;
        end else if (state == ST_FAULT) begin
            ldst_reg      <= 2'b00;
        end
    end

    // Walk / fault sequencing; walk_valid only matters while a walk is outstanding.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_op && !match) begin
                        state <= ST_WALK;
                    end else if (prot_fault) begin
                        state <= ST_FAULT;
                    end
                end
                ST_WALK: begin
                    if (walk_valid) begin
                        state <= walk_fault ? ST_FAULT : ST_IDLE;
                    end
                end
                ST_FAULT: state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

    // Store data comes from the youngest in-flight writer; CACHE is younger than WB.
    always_comb begin
        dataReg_output = data_reg;
        if (is_store) begin
            if (weCACHE && (destReg_addrCACHE == data_addr_reg)) begin
                dataReg_output = cache_result;
            end else if (weWB && (destReg_addrWB == data_addr_reg)) begin
                dataReg_output = wb_result;
            end
        end
    end

    assign tlblookup_result    = {match_ppn, va_reg[PAGE_BITS-1:0]};
    assign destReg_addr_output = dest_reg;
    assign we_output           = nop_out ? 1'b0  : we_reg;
    assign bp_output           = nop_out ? 2'b00 : bp_reg;
    assign ldSt_enable_output  = nop_out ? 2'b00 : ldst_reg;
    assign blockPreviousStages = block;
    assign walk_req            = (state == ST_WALK);
    assign walk_vpn            = (state == ST_WALK) ? cur_vpn : '0;
    assign exc_valid           = (state == ST_FAULT);
    assign exc_vaddr           = (state == ST_FAULT) ? va_reg : '0;

endmodule

// File: doc/dtlb_lookup_stage.md
# dtlb_lookup_stage

Parametrised data-TLB lookup pipeline stage between ALU and CACHE. It latches the ALU-stage instruction, translates the virtual address through a fully associative TLB, and requests a page-table walk from the memory arbiter on a miss, stalling earlier stages until the walk completes. It also flags page and write-protection faults, and forwards store data from the CACHE and WB stages.

## Interface
- VADDR_WIDTH, 16, virtual address width
- PADDR_WIDTH, 20, physical address width
- PAGE_BITS, 12, page-offset width (VPN = VADDR_WIDTH-PAGE_BITS, PPN = PADDR_WIDTH-PAGE_BITS)
- NUM_ENTRIES, 4, TLB entries (>=2)
- DATA_WIDTH, 16, register data width
- REG_ADDR_WIDTH, 3, register index width

Ports:
- clk  in  1  clock; one clock, all state on rising edge
- reset  in  1  synchronous, active-high
- enable_tlblookup  in  1  stage-register load enable from pipeline control
- tlb_flush  in  1  invalidate all entries
- alu_result  in  VADDR_WIDTH  virtual address
- dataReg, dataReg_addr  in  DATA_WIDTH, REG_ADDR_WIDTH  store data and its source register
- ldSt_enable  in  2  bit0 load, bit1 store (2'b11 treated as store)
- destReg_addr_input, we_input, bp_input  in  REG_ADDR_WIDTH, 1, 2  forwarded fields
- tlblookup_result  out  PADDR_WIDTH  physical address {PPN, offset}
- destReg_addr_output, we_output, bp_output, ldSt_enable_output, dataReg_output  out  forwarded fields
- blockPreviousStages  out  1  stall request
- walk_req  out  1; walk_vpn  out  VPN  walk request to arbiter
- walk_valid, walk_fault, walk_writable  in  1; walk_ppn  in  PPN  walk response
- exc_valid  out  1; exc_vaddr  out  VADDR_WIDTH  fault report
- destReg_addrCACHE, weCACHE, cache_result; destReg_addrWB, weWB, wb_result  in  bypass sources

## Operation
- Stage register (all inputs) loads when enable_tlblookup && !blockPreviousStages.
- Entry: valid, VPN, PPN, writable. Lookup is combinational on the registered VPN; at most one match.
- mem_op = ldSt_enable_output_reg != 0. hit = match && (!store || writable).
- Not writable + store + match: fault, no walk.
- FSM states:
  - IDLE: mem_op && no match → WALK, block=1. mem_op && protection fault → FAULT, block=1. Otherwise pass through.
  - WALK: walk_req=1, walk_vpn=registered VPN, block=1.
    - walk_valid && !walk_fault → fill entry, → IDLE.
    - walk_valid && walk_fault → FAULT.
  - FAULT, one cycle: exc_valid=1, exc_vaddr=registered VA, block=0, outputs nop.
    - Stage register loads the next instruction if enabled; otherwise its ldSt bits are cleared.
    - → IDLE.
- Fill victim: lowest-index invalid entry, else round-robin pointer. The pointer advances, wrapping at NUM_ENTRIES-1, only when it is used.
- tlb_flush clears all valid bits. If it coincides with a fill, flush wins, the fill is dropped, and the instruction re-walks.
- Whenever block=1 or in FAULT: we_output=0, bp_output=0, ldSt_enable_output=0 (nop downstream).
- Store-data bypass, applied only when the registered op is a store:
  - dataReg_addr matches destReg_addrCACHE with weCACHE → cache_result.
  - Else matches destReg_addrWB with weWB → wb_result.
  - Else registered data. CACHE has priority.

## Timing
- Reset: all entries invalid, pointer 0, FSM IDLE, stage register 0. Consequently every output is 0, including walk_req, exc_valid and blockPreviousStages.
- Hit: zero added latency; tlblookup_result is valid in the cycle the instruction occupies the stage.
- Miss: block asserts combinationally in cycle t. walk_req is asserted from t+1 until the cycle walk_valid=1 (W) inclusive. The entry is written at the end of W. Hit and release occur at W+1.
- walk_valid is ignored outside WALK. walk_req is never dropped before walk_valid.
- Reset mid-walk: FSM returns to IDLE, walk_req=0 next cycle, entries invalidated.

## Test plan
- Reset, then load VA 0x1234 (VPN 1) → miss. walk_req=1, walk_vpn=1. Respond ppn 0x05 after 3 cycles → tlblookup_result=0x05234 at W+1, block=1 for exactly 5 cycles.
- Repeat load to 0x1FFF → hit, result 0x05FFF, block=0, no walk_req.
- Fill 5 distinct VPNs with NUM_ENTRIES=4 → entries 0..3 are filled, then the 5th replaces entry 0. A re-access to the first VPN misses again.
- Store to a page filled with walk_writable=0 → exc_valid pulse of one cycle, exc_vaddr=store VA, ldSt_enable_output=0, no walk_req.
- Walk returns walk_fault=1 → FAULT for one cycle, exc_valid=1, then IDLE. tlb_flush in the same cycle as a fill → entry invalid, re-walk issued.
- Store with dataReg_addr=3: destReg_addrCACHE=3/weCACHE=1 → cache_result. Only WB matching → wb_result. weCACHE=0 → WB or register data.
